// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the pc_sequencer control block.
// State encoding, width defaults and SZCV flag bit positions live here.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam int          PC_W_DEF     = 12;
    localparam int          IW_DEF       = 16;
    localparam logic [11:0] RESET_PC_DEF = 12'h000;

    localparam int SZCV_W = 4;
    localparam int SZCV_S = 3;
    localparam int SZCV_Z = 2;
    localparam int SZCV_C = 1;
    localparam int SZCV_V = 0;

endpackage

// File: rtl/pc_seq_perf.sv
// Instruction and taken-branch counters for pc_sequencer.
// Built only when PC_SEQ_PERF_EN is defined; both counters wrap at 2^32.
module pc_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_wb,
    input  logic        i_taken,
    output logic [31:0] o_instr_cnt,
    output logic [31:0] o_taken_cnt
);

    logic [31:0] r_instr_cnt;
    logic [31:0] r_taken_cnt;

    // A start is never accepted in WB, so clear and increment cannot collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_cnt <= '0;
            r_taken_cnt <= '0;
        end else if (i_clear) begin
            r_instr_cnt <= '0;
            r_taken_cnt <= '0;
        end else if (i_wb) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
            if (i_taken) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign o_instr_cnt = r_instr_cnt;
    assign o_taken_cnt = r_taken_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH -> EXEC -> WB sequencer owning the PC and SZCV flags.
// Optional performance counters are enabled with the PC_SEQ_PERF_EN macro.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              IW       = IW_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IW-1:0]     imem_rdata,
    output logic [PC_W-1:0]   pc_o,
    output logic [IW-1:0]     instr_o,
    output logic [SZCV_W-1:0] szcv_o,
    input  logic              jflag,
    input  logic [PC_W-1:0]   jdest,
    input  logic              is_halt,
    input  logic              exec_done,
    input  logic [SZCV_W-1:0] szcv_in,
    input  logic              szcv_we,
    output logic              ph_exec,
    output logic              ph_wb,
    output logic              halted
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       taken_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [IW-1:0]     r_instr;
    logic [IW-1:0]     w_instr_next;
    logic [SZCV_W-1:0] r_szcv;
    logic [SZCV_W-1:0] w_szcv_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_szcv  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_szcv  <= w_szcv_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_szcv_next  = r_szcv;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_pc_next    = RESET_PC;
                    w_szcv_next  = '0;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_instr_next = imem_rdata;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // HALT wins over exec_done so the halted PC still names the HALT.
                if (is_halt) begin
                    w_state_next = ST_HALT;
                end else if (exec_done) begin
                    w_state_next = ST_WB;
                end
            end
            ST_WB: begin
                // jflag was computed from r_szcv, i.e. the flags before this update.
                w_pc_next = jflag ? jdest : r_pc + PC_W'(1);
                if (szcv_we) begin
                    w_szcv_next = szcv_in;
                end
                w_state_next = ST_FETCH;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign pc_o      = r_pc;
    assign instr_o   = r_instr;
    assign szcv_o    = r_szcv;
    assign ph_exec   = (r_state == ST_EXEC);
    assign ph_wb     = (r_state == ST_WB);
    assign halted    = (r_state == ST_HALT);

`ifdef PC_SEQ_PERF_EN
    logic w_start_acc;
    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));

    pc_seq_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start_acc),
        .i_wb        (ph_wb),
        .i_taken     (jflag),
        .o_instr_cnt (instr_cnt),
        .o_taken_cnt (taken_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan steps then random traffic.
// A phase-level model predicts every output each cycle; PC_SEQ_PERF_EN adds counter checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [11:0] pc_o;
    logic [15:0] instr_o;
    logic [3:0]  szcv_o;
    logic        jflag;
    logic [11:0] jdest;
    logic        is_halt;
    logic        exec_done;
    logic [3:0]  szcv_in;
    logic        szcv_we;
    logic        ph_exec;
    logic        ph_wb;
    logic        halted;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] instr_cnt;
    logic [31:0] taken_cnt;
`endif

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_o       (pc_o),
        .instr_o    (instr_o),
        .szcv_o     (szcv_o),
        .jflag      (jflag),
        .jdest      (jdest),
        .is_halt    (is_halt),
        .exec_done  (exec_done),
        .szcv_in    (szcv_in),
        .szcv_we    (szcv_we),
        .ph_exec    (ph_exec),
        .ph_wb      (ph_wb),
        .halted     (halted)
`ifdef PC_SEQ_PERF_EN
        ,
        .instr_cnt  (instr_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: which phase the instruction is in plus architectural state.
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_WB = 3, P_HALT = 4;
    int          m_ph    = P_IDLE;
    int          m_pc    = 0;
    logic [15:0] m_instr = '0;
    logic [3:0]  m_szcv  = '0;
    longint      m_icnt  = 0;
    longint      m_tcnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= P_IDLE; m_pc <= 0; m_instr <= '0; m_szcv <= '0;
            m_icnt <= 0; m_tcnt <= 0;
        end else begin
            if (m_ph == P_IDLE || m_ph == P_HALT) begin
                if (start) begin
                    m_ph <= P_FETCH; m_pc <= 0; m_szcv <= '0;
                    m_icnt <= 0; m_tcnt <= 0;
                end
            end else if (m_ph == P_FETCH) begin
                if (imem_ack) begin
                    m_instr <= imem_rdata;
                    m_ph <= P_EXEC;
                end
            end else if (m_ph == P_EXEC) begin
                if (is_halt) m_ph <= P_HALT;
                else if (exec_done) m_ph <= P_WB;
            end else begin
                m_pc <= jflag ? int'(jdest) : (m_pc + 1) % 4096;
                if (szcv_we) m_szcv <= szcv_in;
                m_icnt <= (m_icnt + 1) % 64'h1_0000_0000;
                if (jflag) m_tcnt <= (m_tcnt + 1) % 64'h1_0000_0000;
                m_ph <= P_FETCH;
            end
        end
    end

    always @(negedge clk) begin
        check("imem_req", {31'd0, imem_req}, {31'd0, m_ph == P_FETCH});
        if (m_ph == P_FETCH) check("imem_addr", {20'd0, imem_addr}, m_pc);
        check("pc_o", {20'd0, pc_o}, m_pc);
        check("instr_o", {16'd0, instr_o}, {16'd0, m_instr});
        check("szcv_o", {28'd0, szcv_o}, {28'd0, m_szcv});
        check("ph_exec", {31'd0, ph_exec}, {31'd0, m_ph == P_EXEC});
        check("ph_wb", {31'd0, ph_wb}, {31'd0, m_ph == P_WB});
        check("halted", {31'd0, halted}, {31'd0, m_ph == P_HALT});
`ifdef PC_SEQ_PERF_EN
        check("instr_cnt", instr_cnt, m_icnt[31:0]);
        check("taken_cnt", taken_cnt, m_tcnt[31:0]);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH with immediate ack/exec_done; jflag is garbage outside WB.
    task automatic run_instr(input logic jf, input logic [11:0] jd, input logic we,
                             input logic [3:0] sin, input logic hl);
        jflag = 1'b1; jdest = 12'hABC;
        imem_ack = 1'b1; imem_rdata = 16'($urandom);
        tick();
        imem_ack = 1'b0; exec_done = 1'b1; is_halt = hl;
        tick();
        exec_done = 1'b0; is_halt = 1'b0;
        if (!hl) begin
            jflag = jf; jdest = jd; szcv_we = we; szcv_in = sin;
            tick();
            jflag = 1'b1; jdest = 12'h5A5; szcv_we = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        jflag = 1'b0; jdest = '0; is_halt = 1'b0; exec_done = 1'b0;
        szcv_in = '0; szcv_we = 1'b0;
        repeat (3) tick();
        check("rst_pc", {20'd0, pc_o}, 32'h000);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("start_req", {31'd0, imem_req}, 32'd1);
        check("start_addr", {20'd0, imem_addr}, 32'h000);
        tick();
        rst_n = 1'b0; #1;
        check("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
        check("midfetch_rst_instr", {16'd0, instr_o}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        imem_ack = 1'b0; rst_n = 1'b1;
        tick();
        check("idle_after_rst", {31'd0, imem_req}, 32'd0);
        check("idle_instr", {16'd0, instr_o}, 32'd0);

        // Sequential flow at 3 cycles per instruction.
        start = 1'b1; tick(); start = 1'b0;
        imem_ack = 1'b1; exec_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("seq_addr", {20'd0, imem_addr}, k);
            tick(); check("seq_exec", {31'd0, ph_exec}, 32'd1);
            tick(); check("seq_wb", {31'd0, ph_wb}, 32'd1);
            tick(); check("seq_wb_one", {31'd0, ph_wb}, 32'd0);
        end

        // Wait states: 5 FETCH, 2 EXEC, 1 WB.
        imem_ack = 1'b0; exec_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("ws_req", {31'd0, imem_req}, 32'd1);
            check("ws_addr", {20'd0, imem_addr}, 32'h003);
            tick();
        end
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        check("ws_exec1", {31'd0, ph_exec}, 32'd1);
        tick(); check("ws_exec2", {31'd0, ph_exec}, 32'd1);
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        check("ws_wb", {31'd0, ph_wb}, 32'd1);
        tick(); check("ws_next_addr", {20'd0, imem_addr}, 32'h004);

        // Branches, flags and PC wrap.
        run_instr(1'b1, 12'h010, 1'b0, 4'h0, 1'b0);
        check("br_to_010", {20'd0, imem_addr}, 32'h010);
        run_instr(1'b1, 12'h00C, 1'b0, 4'h0, 1'b0);
        check("br_to_00C", {20'd0, imem_addr}, 32'h00C);
        run_instr(1'b0, 12'h000, 1'b1, 4'b0100, 1'b0);
        check("nojump_00D", {20'd0, imem_addr}, 32'h00D);
        check("flags_0100", {28'd0, szcv_o}, 32'h4);
        run_instr(1'b1, 12'hFFF, 1'b0, 4'h0, 1'b0);
        run_instr(1'b0, 12'h000, 1'b0, 4'h0, 1'b0);
        check("wrap_000", {20'd0, imem_addr}, 32'h000);

        // Halt with exec_done also high, then restart.
        run_instr(1'b1, 12'h020, 1'b0, 4'h0, 1'b0);
        run_instr(1'b0, 12'h000, 1'b0, 4'h0, 1'b1);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_pc", {20'd0, pc_o}, 32'h020);
        tick(); tick();
        check("halt_pc_hold", {20'd0, pc_o}, 32'h020);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", {20'd0, imem_addr}, 32'h000);
        check("restart_szcv", {28'd0, szcv_o}, 32'd0);
`ifdef PC_SEQ_PERF_EN
        check("restart_icnt", instr_cnt, 32'd0);
        check("restart_tcnt", taken_cnt, 32'd0);
`endif

        // Randomized traffic, including stray acks, starts and resets.
        for (int n = 0; n < 4000; n++) begin
            rst_n      = ($urandom_range(0, 499) != 0);
            start      = ($urandom_range(0, 19) == 0);
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = 16'($urandom);
            exec_done  = ($urandom_range(0, 1) == 0);
            is_halt    = ($urandom_range(0, 29) == 0);
            jflag      = 1'($urandom);
            jdest      = 12'($urandom);
            szcv_in    = 4'($urandom);
            szcv_we    = 1'($urandom);
            tick();
        end
        rst_n = 1'b1; start = 1'b0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit/12-bit-PC core. Owns the program counter and the SZCV flag register, fetches instructions over a variable-latency imem handshake, and steps each instruction through FETCH -> EXEC -> WB. In WB it commits the next PC from the jump-calculation unit (jflag/jdest) or pc+1. It drives that unit's pc/instr/szcv inputs.

Parameters:
PC_W, 12, program counter / imem address width
IW, 16, instruction width
RESET_PC, 12'h000, PC loaded on start

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin execution at RESET_PC (honoured in IDLE and HALT only)
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  PC_W  fetch address (= pc_o while imem_req)
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  IW  fetched instruction
pc_o  out  PC_W  address of current instruction (to jump calc)
instr_o  out  IW  latched current instruction (to decoder, jump calc)
szcv_o  out  4  flag register {s,z,c,v} (to jump calc)
jflag  in  1  branch taken, from jump calc
jdest  in  PC_W  branch target, from jump calc
is_halt  in  1  decoder: instr_o is HALT
exec_done  in  1  datapath: EXEC work complete
szcv_in  in  4  new flags from ALU
szcv_we  in  1  commit szcv_in in WB
ph_exec  out  1  high in EXEC
ph_wb  out  1  high for the single WB cycle (register-file write enable qualifier)
halted  out  1  high in HALT

Behaviour:
- Reset (async, any state): state=IDLE; pc_o=RESET_PC; instr_o=0; szcv_o=0; imem_req, ph_exec, ph_wb, halted = 0. In-flight fetch is abandoned; a late imem_ack is ignored.
- States IDLE, FETCH, EXEC, WB, HALT; all outputs registered or decoded from state only.
- IDLE: start -> pc<=RESET_PC, szcv<=0, go FETCH.
- FETCH: imem_req=1, imem_addr=pc_o, stable until ack. imem_ack -> instr_o<=imem_rdata, go EXEC. Ack on first FETCH cycle allowed.
- EXEC: ph_exec=1. is_halt has priority -> HALT (pc_o unchanged, exec_done ignored). Else exec_done -> WB. Else stay.
- WB, exactly one cycle: ph_wb=1. pc<=jflag ? jdest : pc_o+1, modulo 2^PC_W (12'hFFF+1 -> 12'h000). szcv<=szcv_in if szcv_we. Then go FETCH.
- Flag timing: jflag is sampled in WB against szcv_o before this WB's update. A branch therefore sees the flags of the previous flag-writing instruction.
- jflag/jdest are ignored outside WB; jflag is not required to be valid in other states.
- Minimum throughput is 3 cycles/instruction (ack and exec_done both in their first cycle).
- HALT: halted=1, no fetch. start -> behave as IDLE start (pc<=RESET_PC, szcv<=0, FETCH).
- start in FETCH/EXEC/WB is ignored. imem_ack outside FETCH is ignored.

Optional Feature:
PC_SEQ_PERF_EN
- Defined: adds outputs instr_cnt[31:0] and taken_cnt[31:0].
  - instr_cnt +1 every WB; taken_cnt +1 in WB when jflag.
  - Both wrap at 2^32, reset to 0, and clear on an accepted start.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package pc_seq_pkg: state enum (IDLE, FETCH, EXEC, WB, HALT), PC_W/IW defaults, RESET_PC default, SZCV bit-index constants (S=3, Z=2, C=1, V=0).
- Sub-module pc_seq_perf holds the two counters, instantiated only under PC_SEQ_PERF_EN.
- FSM, PC and flag register stay in pc_sequencer.

Test Plan:
- Reset/start: rst_n low mid-FETCH with imem_req=1 -> all outputs reset values, IDLE. start -> imem_req=1, imem_addr=12'h000 next cycle.
- Sequential flow: ack and exec_done immediate, no jumps -> pc_o 000,001,002 at 3-cycle spacing; ph_wb one cycle each.
- Wait states: ack delayed 4 cycles, exec_done delayed 2 -> imem_req/addr stable throughout; instruction takes 1+4+2+1 = 8 cycles total (5 FETCH, 2 EXEC, 1 WB).
- Branch: pc=12'h010, jflag=1, jdest=12'h00C in WB -> next imem_addr=12'h00C. jflag toggled outside WB -> no effect.
- Flags/wrap: szcv_we=1, szcv_in=4'b0100 in WB -> szcv_o=4'b0100 from next cycle. pc=12'hFFF without jump -> next pc=12'h000.
- Halt: is_halt and exec_done both in EXEC at pc=12'h020 -> HALT, halted=1, no imem_req, pc_o stays 12'h020. start -> fetch at 12'h000. With PC_SEQ_PERF_EN, counters read 0 after that start.
